// File: rtl/cursor_entry.sv
// Operator cursor/colour entry: synchronised, debounced KEY[1]/KEY[2] step a
// saturating X/Y cursor with auto-repeat, or load the RGB colour from SW.
module cursor_entry #(
   parameter int X_MAX           = 199,
   parameter int Y_MAX           = 149,
   parameter int DEBOUNCE_CYCLES = 400000,
   parameter int REPEAT_DELAY    = 20000000,
   parameter int REPEAT_RATE     = 4000000
) (
   input  logic       CLK40,
   input  logic       NRST,
   input  logic [9:0] SW,
   input  logic [3:0] KEY,
   output logic [7:0] Xin,
   output logic [7:0] Yin,
   output logic [8:0] RGBin,
   output logic       moved
);
   localparam int DBW     = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW      = $clog2(RPT_MAX + 1);
   localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
   localparam logic [DBW-1:0] DB_ONE  = DBW'(1);
   localparam logic [RW-1:0]  RD_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0]  RR_LAST = RW'(REPEAT_RATE - 1);
   localparam logic [RW-1:0]  RP_ONE  = RW'(1);
   localparam logic [7:0]     XM      = 8'(X_MAX);
   localparam logic [7:0]     YM      = 8'(Y_MAX);

   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} st_t;

   logic           unused_keys;
   logic [9:0]     sw_s1_q, sw_s2_q;
   logic [1:0]     key_s1_q, key_s2_q;            // [0] = KEY[1], [1] = KEY[2]
   logic [1:0]     stb_q, stb_d, stb_p_q;
   logic [DBW-1:0] db_cnt_q [2];
   logic [DBW-1:0] db_cnt_d [2];
   logic [1:0]     press;
   logic           excl, press_ok, inc, mode, sel_y, step_ev;
   st_t            st_q, st_d;
   logic [RW-1:0]  rp_cnt_q, rp_cnt_d;
   logic [7:0]     fld, fmax, nfld;
   logic [8:0]     stp9, sum9, dif9;
   logic [7:0]     x_q, x_d, y_q, y_d;
   logic [8:0]     rgb_q, rgb_d;
   logic           chg_q, moved_q;

   assign unused_keys = ^{KEY[3], KEY[0]};

   always_ff @(posedge CLK40) begin
      if (!NRST) begin
         sw_s1_q  <= '1;
         sw_s2_q  <= '1;
         key_s1_q <= '1;
         key_s2_q <= '1;
      end else begin
         sw_s1_q  <= SW;
         sw_s2_q  <= sw_s1_q;
         key_s1_q <= KEY[2:1];
         key_s2_q <= key_s1_q;
      end
   end

   // Any return to the stable level restarts the count.
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         stb_d[k]    = stb_q[k];
         db_cnt_d[k] = '0;
         if (key_s2_q[k] != stb_q[k]) begin
            if (db_cnt_q[k] == DB_LAST) stb_d[k] = key_s2_q[k];
            else                        db_cnt_d[k] = db_cnt_q[k] + DB_ONE;
         end
      end
   end

   always_ff @(posedge CLK40) begin
      if (!NRST) begin
         stb_q       <= '1;
         stb_p_q     <= '1;
         db_cnt_q[0] <= '0;
         db_cnt_q[1] <= '0;
      end else begin
         stb_q       <= stb_d;
         stb_p_q     <= stb_q;
         db_cnt_q[0] <= db_cnt_d[0];
         db_cnt_q[1] <= db_cnt_d[1];
      end
   end

   // With exactly one key down, that key identifies the direction.
   assign press    = stb_p_q & ~stb_q;
   assign excl     = stb_q[0] ^ stb_q[1];
   assign press_ok = (|press) & excl;
   assign inc      = ~stb_q[1];
   assign mode     = sw_s2_q[9];
   assign sel_y    = sw_s2_q[8];

   always_ff @(posedge CLK40) begin
      if (!NRST) begin
         st_q     <= IDLE;
         rp_cnt_q <= '0;
      end else begin
         st_q     <= st_d;
         rp_cnt_q <= rp_cnt_d;
      end
   end

   always_comb begin
      st_d = st_q;
      case (st_q)
         IDLE:    if (press_ok && !mode) st_d = HOLD;
         HOLD:    if (!excl || mode) st_d = IDLE;
                  else if (rp_cnt_q == RD_LAST) st_d = REPEAT;
         REPEAT:  if (!excl || mode) st_d = IDLE;
         default: st_d = IDLE;
      endcase
   end

   always_comb begin
      step_ev  = 1'b0;
      rp_cnt_d = rp_cnt_q + RP_ONE;
      case (st_q)
         IDLE: begin
            rp_cnt_d = '0;
            step_ev  = press_ok && !mode;
         end
         HOLD:
            if (!excl || mode) rp_cnt_d = '0;
            else if (rp_cnt_q == RD_LAST) begin
               step_ev  = 1'b1;
               rp_cnt_d = '0;
            end
         REPEAT:
            if (!excl || mode) rp_cnt_d = '0;
            else if (rp_cnt_q == RR_LAST) begin
               step_ev  = 1'b1;
               rp_cnt_d = '0;
            end
         default: rp_cnt_d = '0;
      endcase
   end

   assign fld  = sel_y ? y_q : x_q;
   assign fmax = sel_y ? YM : XM;
   assign stp9 = sw_s2_q[7] ? 9'd10 : 9'd1;
   assign sum9 = {1'b0, fld} + stp9;
   assign dif9 = {1'b0, fld} - stp9;
   assign nfld = inc ? ((sum9 > {1'b0, fmax}) ? fmax : sum9[7:0])
                     : (dif9[8] ? 8'd0 : dif9[7:0]);

   always_comb begin
      x_d   = x_q;
      y_d   = y_q;
      rgb_d = rgb_q;
      if (step_ev) begin
         if (sel_y) y_d = nfld;
         else       x_d = nfld;
      end
      if (press_ok && mode) rgb_d = inc ? sw_s2_q[8:0] : 9'h1FF;
   end

   // moved trails the value change by one cycle, hence the extra stage.
   always_ff @(posedge CLK40) begin
      if (!NRST) begin
         x_q     <= '0;
         y_q     <= '0;
         rgb_q   <= 9'h1FF;
         chg_q   <= 1'b0;
         moved_q <= 1'b0;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         rgb_q   <= rgb_d;
         chg_q   <= (x_d != x_q) || (y_d != y_q);
         moved_q <= chg_q;
      end
   end

   assign Xin   = x_q;
   assign Yin   = y_q;
   assign RGBin = rgb_q;
   assign moved = moved_q;
endmodule

// File: tb/tb_cursor_entry.sv
// Bench for cursor_entry with short debounce/repeat parameters: tap tables
// checked through a scoreboard queue plus hand-written timing sequences.
module tb_cursor_entry;
   logic       CLK40 = 1'b0;
   logic       NRST  = 1'b0;
   logic [9:0] SW    = '0;
   logic [3:0] KEY   = 4'hF;
   logic [7:0] Xin, Yin;
   logic [8:0] RGBin;
   logic       moved;
   int         n_cmp = 0;
   int         n_bad = 0;

   typedef struct {
      logic [9:0] sw;
      int         key;
      int         hold;
      logic [7:0] x;
      logic [7:0] y;
      logic [8:0] rgb;
      int         mv;
   } vec_t;

   vec_t tab_a[$];
   vec_t tab_b[$];
   vec_t sb[$];
   int   sb_t[$];

   always #5 CLK40 = ~CLK40;

   cursor_entry #(
      .X_MAX(199), .Y_MAX(149),
      .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(5)
   ) dut (
      .CLK40(CLK40), .NRST(NRST), .SW(SW), .KEY(KEY),
      .Xin(Xin), .Yin(Yin), .RGBin(RGBin), .moved(moved)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Advance n cycles, sampling moved at each falling edge.
   task automatic step_cnt(input int n, inout int mv);
      repeat (n) begin
         @(posedge CLK40);
         @(negedge CLK40);
         if (moved === 1'b1) mv++;
      end
   endtask

   task automatic do_reset(input int n);
      NRST = 1'b0;
      repeat (n) @(posedge CLK40);
      @(negedge CLK40);
      chk("reset Xin", Xin, 0);
      chk("reset Yin", Yin, 0);
      chk("reset RGBin", RGBin, 9'h1FF);
      chk("reset moved", moved, 0);
      NRST = 1'b1;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int   mv;
      vec_t e;
      mv = 0;
      sb.push_back(v);
      SW = v.sw;
      step_cnt(3, mv);
      KEY[v.key] = 1'b0;
      step_cnt(v.hold, mv);
      KEY[v.key] = 1'b1;
      step_cnt(14, mv);
      e = sb.pop_front();
      chk({tag, " Xin"}, Xin, e.x);
      chk({tag, " Yin"}, Yin, e.y);
      chk({tag, " RGBin"}, RGBin, e.rgb);
      chk({tag, " moved pulses"}, mv, e.mv);
   endtask

   initial begin
      int xe, nx, mv, lat, px;

      xe = 1;
      for (int i = 0; i < 25; i++) begin
         nx = (xe + 10 > 199) ? 199 : xe + 10;
         tab_a.push_back('{10'h080, 2, 10, 8'(nx), 8'd0, 9'h1FF, (nx != xe) ? 1 : 0});
         xe = nx;
      end
      for (int i = 1; i <= 5; i++)
         tab_a.push_back('{10'h100, 2, 10, 8'd199, 8'(i), 9'h1FF, 1});
      tab_a.push_back('{10'h180, 1, 10, 8'd199, 8'd0, 9'h1FF, 1});
      tab_a.push_back('{10'h180, 1, 10, 8'd199, 8'd0, 9'h1FF, 0});
      tab_a.push_back('{10'h080, 1, 10, 8'd189, 8'd0, 9'h1FF, 1});
      tab_a.push_back('{10'h000, 1, 10, 8'd188, 8'd0, 9'h1FF, 1});

      tab_b.push_back('{10'h353, 2, 50, 8'd9, 8'd0, 9'h153, 0});
      tab_b.push_back('{10'h353, 1, 10, 8'd9, 8'd0, 9'h1FF, 0});
      tab_b.push_back('{10'h238, 2, 10, 8'd9, 8'd0, 9'h038, 0});
      tab_b.push_back('{10'h238, 1, 10, 8'd9, 8'd0, 9'h1FF, 0});

      do_reset(3);
      mv = 0;
      step_cnt(3, mv);

      // Press latency: output on the 7th edge, moved on the 8th.
      KEY[2] = 1'b0;
      repeat (6) @(posedge CLK40);
      @(negedge CLK40);
      chk("latency Xin before edge 7", Xin, 0);
      @(posedge CLK40);
      @(negedge CLK40);
      chk("latency Xin at edge 7", Xin, 1);
      chk("latency moved at edge 7", moved, 0);
      @(posedge CLK40);
      @(negedge CLK40);
      chk("latency moved at edge 8", moved, 1);
      @(posedge CLK40);
      @(negedge CLK40);
      chk("latency moved at edge 9", moved, 0);
      KEY[2] = 1'b1;
      step_cnt(14, mv);

      for (int i = 0; i < tab_a.size(); i++) run_vec(tab_a[i], $sformatf("tabA[%0d]", i));

      // Auto-repeat, then a second key stops it.
      SW = 10'h000;
      do_reset(3);
      step_cnt(3, mv);
      for (int t = 20; t <= 55; t += 5) sb_t.push_back(t);
      KEY[2] = 1'b0;
      lat = 21;
      for (int i = 1; i <= 20; i++) begin
         @(posedge CLK40);
         @(negedge CLK40);
         if (Xin != 0) begin
            lat = i;
            break;
         end
      end
      chk("repeat first step latency", lat, 7);
      chk("repeat first step Xin", Xin, 1);
      px = Xin;
      for (int t = 1; t <= 90; t++) begin
         @(posedge CLK40);
         @(negedge CLK40);
         if (Xin != px) begin
            if (sb_t.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL repeat extra step: got step at t=%0d, expected none", t);
            end else chk("repeat step time", t, sb_t.pop_front());
            px = Xin;
         end
         if (t == 51) KEY[1] = 1'b0;
      end
      chk("repeat steps outstanding", sb_t.size(), 0);
      chk("repeat final Xin", Xin, 9);
      KEY[2:1] = 2'b11;
      step_cnt(14, mv);

      // Glitches shorter than the debounce window.
      mv = 0;
      for (int g = 0; g < 5; g++) begin
         KEY[2] = 1'b0;
         step_cnt(3, mv);
         KEY[2] = 1'b1;
         step_cnt(4, mv);
      end
      step_cnt(10, mv);
      chk("glitch Xin", Xin, 9);
      chk("glitch moved pulses", mv, 0);

      // Both keys pressed together.
      mv = 0;
      KEY[2:1] = 2'b00;
      step_cnt(20, mv);
      KEY[2:1] = 2'b11;
      step_cnt(14, mv);
      chk("both keys Xin", Xin, 9);
      chk("both keys Yin", Yin, 0);
      chk("both keys RGBin", RGBin, 9'h1FF);
      chk("both keys moved pulses", mv, 0);

      for (int i = 0; i < tab_b.size(); i++) run_vec(tab_b[i], $sformatf("tabB[%0d]", i));

      // Reset during a hold; the held key registers again afterwards.
      SW = 10'h238;
      step_cnt(3, mv);
      KEY[2] = 1'b0;
      step_cnt(10, mv);
      chk("pre-reset RGBin", RGBin, 9'h038);
      do_reset(2);
      repeat (6) @(posedge CLK40);
      @(negedge CLK40);
      chk("post-reset RGBin before re-press", RGBin, 9'h1FF);
      @(posedge CLK40);
      @(negedge CLK40);
      chk("post-reset RGBin re-press", RGBin, 9'h038);
      chk("post-reset Xin", Xin, 0);
      KEY[2] = 1'b1;
      step_cnt(14, mv);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
